// File: rtl/latch_bank_arbiter_pkg.sv
// Shared constants for the latch bank write controller.
// State encoding and parameter defaults.
package latch_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_GATE  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  localparam int NREQ_D       = 4;
  localparam int WIDTH_D      = 8;
  localparam int CLR_CYCLES_D = 2;

  localparam int IDW = $clog2(NREQ_D);

endpackage

// File: rtl/latch_bank_arbiter_if.sv
// Requester handshake plus latch bank drive signals.
// master = requesters/bank side, slave = arbiter.
interface latch_bank_arbiter_if
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ  = NREQ_D,
  parameter int WIDTH = WIDTH_D
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  clr_req;
  logic [NREQ-1:0]       ack;
  logic                  clr_ack;
  logic                  busy;
  logic [GW-1:0]         grant_id;
  logic [WIDTH-1:0]      lat_d;
  logic                  lat_g;
  logic                  lat_clr_n;

  modport master (
    output req, wdata, clr_req,
    input  ack, clr_ack, busy, grant_id,
    input  lat_d, lat_g, lat_clr_n
  );

  modport slave (
    input  req, wdata, clr_req,
    output ack, clr_ack, busy, grant_id,
    output lat_d, lat_g, lat_clr_n
  );

endinterface

// File: rtl/latch_bank_arbiter_rr_picker.sv
// Round-robin picker: rotate by ptr, fixed
// priority, then un-rotate the winner index.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner
);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  pos;
  logic            hit;

  always_comb begin
    rot    = '0;
    pos    = '0;
    hit    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[IDW'((i + int'(ptr)) % NREQ)];
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i] && !hit) begin
        hit = 1'b1;
        pos = IDW'(i);
      end
    end
    winner = IDW'((int'(pos) + int'(ptr)) % NREQ);
  end

  assign any = |req;

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin write controller for a shared bank of
// gated D-latches: setup -> gate -> hold, plus clear.
module latch_bank_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ       = NREQ_D,
  parameter int WIDTH      = WIDTH_D,
  parameter int CLR_CYCLES = CLR_CYCLES_D
) (
  input logic                 clk,
  input logic                 rst,
  latch_bank_arbiter_if.slave bus
);

  localparam int GW = $clog2(NREQ);
  localparam int CW =
    (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLAST =
    CW'(CLR_CYCLES - 1);

  logic [2:0]       state;
  logic [GW-1:0]    ptr;
  logic [GW-1:0]    gid;
  logic [GW-1:0]    nptr;
  logic [GW-1:0]    win;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  gmask;
  logic [NREQ-1:0]  pick_req;
  logic             any;
  logic [WIDTH-1:0] slice;

  logic [WIDTH-1:0] d_q;
  logic             g_q;
  logic             clrn_q;
  logic [NREQ-1:0]  ack_q;
  logic             cack_q;
  logic             busy_q;

  assign gmask = NREQ'(1) << gid;

  // In HOLD the acked requester still shows its old
  // request level; keep it out of the next pick.
  assign pick_req = (state == S_HOLD)
                  ? (bus.req & ~gmask)
                  : bus.req;

  assign nptr = (int'(gid) == NREQ - 1)
              ? '0 : gid + GW'(1);

  assign slice =
    bus.wdata[int'(win)*WIDTH +: WIDTH];

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (GW)
  ) u_pick (
    .req    (pick_req),
    .ptr    (ptr),
    .any    (any),
    .winner (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gid    <= '0;
      cnt    <= '0;
      d_q    <= '0;
      g_q    <= 1'b0;
      clrn_q <= 1'b0;
      ack_q  <= '0;
      cack_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= '0;
      cack_q <= 1'b0;
      g_q    <= 1'b0;
      case (state)
        S_SETUP: begin
          state <= S_GATE;
          g_q   <= 1'b1;
        end
        S_GATE: begin
          state <= S_HOLD;
          ack_q <= gmask;
          ptr   <= nptr;
        end
        S_CLEAR: begin
          if (cnt == CLAST) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            clrn_q <= 1'b1;
          end else begin
            cnt    <= cnt + CW'(1);
            cack_q <= (cnt + CW'(1) == CLAST);
          end
        end
        default: begin
          // IDLE and HOLD exit share one decision
          clrn_q <= 1'b1;
          if (bus.clr_req) begin
            state  <= S_CLEAR;
            cnt    <= '0;
            clrn_q <= 1'b0;
            cack_q <= (CLR_CYCLES == 1);
            busy_q <= 1'b1;
          end else if (any) begin
            state  <= S_SETUP;
            gid    <= win;
            d_q    <= slice;
            busy_q <= 1'b1;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.clr_ack   = cack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid;
  assign bus.lat_d     = d_q;
  assign bus.lat_g     = g_q;
  assign bus.lat_clr_n = clrn_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed and random-soak bench for latch_bank_arbiter
// with a behavioural gated D-latch bank model.
module tb_latch_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] q;

  latch_bank_arbiter_if #(.NREQ(N), .WIDTH(W)) bus();

  latch_bank_arbiter #(
    .NREQ(N), .WIDTH(W), .CLR_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_latch begin
    if (!bus.lat_clr_n) q <= '0;
    else if (bus.lat_g) q <= bus.lat_d;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.req = '0;
    bus.clr_req = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_clrn: got %b want 0", bus.lat_clr_n);
    end
    checks++;
    if ({bus.busy, bus.lat_g, bus.clr_ack} !== 3'b000 ||
        bus.ack !== 4'h0 || bus.lat_d !== 8'h00 ||
        bus.grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_outs: got busy=%b g=%b cack=%b ack=%h d=%h gid=%0d want zeros",
               bus.busy, bus.lat_g, bus.clr_ack, bus.ack, bus.lat_d, bus.grant_id);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.lat_clr_n !== 1'b0) begin
      errors++;
      $display("FAIL rel_pre_edge: got clrn=%b want 0", bus.lat_clr_n);
    end
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rel_edge: got clrn=%b busy=%b want 1 0",
               bus.lat_clr_n, bus.busy);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.lat_clr_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got clrn=%b want 0", bus.lat_clr_n);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b1) begin
      errors++;
      $display("FAIL rst_release2: got clrn=%b want 1", bus.lat_clr_n);
    end
  endtask

  task automatic test_single;
    bus.wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.lat_d !== 8'hA5 || bus.grant_id !== 2'd2 ||
        bus.busy !== 1'b1 || bus.lat_g !== 1'b0) begin
      errors++;
      $display("FAIL single_setup: got d=%h gid=%0d busy=%b g=%b want A5 2 1 0",
               bus.lat_d, bus.grant_id, bus.busy, bus.lat_g);
    end
    bus.wdata[23:16] = 8'h3C;
    tick();
    checks++;
    if (bus.lat_g !== 1'b1 || bus.lat_d !== 8'hA5 ||
        bus.ack !== 4'h0) begin
      errors++;
      $display("FAIL single_gate: got g=%b d=%h ack=%h want 1 A5 0",
               bus.lat_g, bus.lat_d, bus.ack);
    end
    tick();
    checks++;
    if (bus.lat_g !== 1'b0 || bus.ack !== 4'b0100 ||
        bus.lat_d !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got g=%b ack=%b d=%h want 0 0100 A5",
               bus.lat_g, bus.ack, bus.lat_d);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.ack !== 4'h0 || bus.busy !== 1'b0 ||
        q !== 8'hA5) begin
      errors++;
      $display("FAIL single_done: got ack=%h busy=%b q=%h want 0 0 A5",
               bus.ack, bus.busy, q);
    end
  endtask

  task automatic test_fairness;
    logic [1:0] idx;
    do_reset();
    bus.wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req = 4'hF;
    for (int w = 0; w < 5; w++) begin
      idx = 2'(w % 4);
      tick();
      checks++;
      if (bus.grant_id !== idx ||
          bus.lat_d !== 8'h10 + 8'(idx) ||
          bus.ack !== 4'h0) begin
        errors++;
        $display("FAIL fair_grant%0d: got gid=%0d d=%h ack=%h want %0d %h 0",
                 w, bus.grant_id, bus.lat_d, bus.ack, idx, 8'h10 + 8'(idx));
      end
      tick();
      checks++;
      if (bus.lat_g !== 1'b1) begin
        errors++;
        $display("FAIL fair_gate%0d: got g=%b want 1", w, bus.lat_g);
      end
      tick();
      checks++;
      if (bus.ack !== 4'(1) << idx) begin
        errors++;
        $display("FAIL fair_ack%0d: got %b want %b",
                 w, bus.ack, 4'(1) << idx);
      end
      if (w == 4) bus.req = 4'h0;
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || q !== 8'h10) begin
      errors++;
      $display("FAIL fair_end: got busy=%b q=%h want 0 10",
               bus.busy, q);
    end
  endtask

  task automatic test_clear_priority;
    bus.wdata[15:8] = 8'h77;
    bus.clr_req = 1'b1;
    bus.req = 4'b0010;
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b0 || bus.busy !== 1'b1 ||
        bus.lat_g !== 1'b0 || bus.clr_ack !== 1'b0 ||
        q !== 8'h00) begin
      errors++;
      $display("FAIL clr_c1: got clrn=%b busy=%b g=%b cack=%b q=%h want 0 1 0 0 00",
               bus.lat_clr_n, bus.busy, bus.lat_g, bus.clr_ack, q);
    end
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b0 || bus.clr_ack !== 1'b1 ||
        bus.ack !== 4'h0) begin
      errors++;
      $display("FAIL clr_c2: got clrn=%b cack=%b ack=%h want 0 1 0",
               bus.lat_clr_n, bus.clr_ack, bus.ack);
    end
    bus.clr_req = 1'b0;
    tick();
    checks++;
    if (bus.lat_clr_n !== 1'b1 || bus.clr_ack !== 1'b0 ||
        bus.busy !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL clr_end: got clrn=%b cack=%b busy=%b q=%h want 1 0 0 00",
               bus.lat_clr_n, bus.clr_ack, bus.busy, q);
    end
    tick();
    checks++;
    if (bus.grant_id !== 2'd1 || bus.lat_d !== 8'h77 ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_then_req: got gid=%0d d=%h busy=%b want 1 77 1",
               bus.grant_id, bus.lat_d, bus.busy);
    end
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b0010) begin
      errors++;
      $display("FAIL clr_req_ack: got %b want 0010", bus.ack);
    end
    bus.req = 4'h0;
    tick();
    checks++;
    if (q !== 8'h77 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_req_q: got q=%h busy=%b want 77 0",
               q, bus.busy);
    end
  endtask

  task automatic test_reset_mid_write;
    bus.wdata[7:0] = 8'h5A;
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.grant_id !== 2'd0 || bus.lat_d !== 8'h5A) begin
      errors++;
      $display("FAIL midrst_grant: got gid=%0d d=%h want 0 5A",
               bus.grant_id, bus.lat_d);
    end
    tick();
    checks++;
    if (bus.lat_g !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gate: got g=%b want 1", bus.lat_g);
    end
    #2;
    rst = 1'b1;
    bus.req = 4'b1000;
    bus.wdata[31:24] = 8'hC3;
    #1;
    checks++;
    if (bus.lat_g !== 1'b0 || bus.lat_clr_n !== 1'b0 ||
        bus.busy !== 1'b0 || bus.ack !== 4'h0 ||
        bus.lat_d !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async: got g=%b clrn=%b busy=%b ack=%h d=%h want 0 0 0 0 00",
               bus.lat_g, bus.lat_clr_n, bus.busy, bus.ack, bus.lat_d);
    end
    tick();
    checks++;
    if (bus.ack !== 4'h0) begin
      errors++;
      $display("FAIL midrst_noack: got %b want 0000", bus.ack);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.grant_id !== 2'd3 || bus.lat_d !== 8'hC3 ||
        bus.lat_clr_n !== 1'b1) begin
      errors++;
      $display("FAIL midrst_regrant: got gid=%0d d=%h clrn=%b want 3 C3 1",
               bus.grant_id, bus.lat_d, bus.lat_clr_n);
    end
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_ack: got %b want 1000", bus.ack);
    end
    bus.req = 4'h0;
    tick();
    checks++;
    if (q !== 8'hC3) begin
      errors++;
      $display("FAIL midrst_q: got %h want C3", q);
    end
  endtask

  task automatic test_soak;
    logic [N-1:0]   pend;
    logic           cpend;
    logic [N*W-1:0] hist [3];
    logic [N*W-1:0] wd;
    logic           pg;
    logic           ppg;
    logic [W-1:0]   expq;
    logic [W-1:0]   exp_d;
    int             n;
    do_reset();
    pend = '0;
    cpend = 1'b0;
    pg = 1'b0;
    ppg = 1'b0;
    expq = '0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    for (int it = 0; it < 200; it++) begin
      tick();
      checks++;
      if (bus.lat_g && !bus.lat_clr_n) begin
        errors++;
        $display("FAIL soak_g_clr%0d: got g=1 clrn=0 want not both", it);
      end
      checks++;
      if (!$onehot0(bus.ack) || (|bus.ack && bus.clr_ack)) begin
        errors++;
        $display("FAIL soak_ack%0d: got ack=%b cack=%b want onehot0 exclusive",
                 it, bus.ack, bus.clr_ack);
      end
      checks++;
      if (bus.lat_g && pg) begin
        errors++;
        $display("FAIL soak_gwidth%0d: got g high 2 cycles want 1", it);
      end
      checks++;
      if ((bus.ack & ~pend) != '0) begin
        errors++;
        $display("FAIL soak_spurious%0d: got ack=%b want subset of %b",
                 it, bus.ack, pend);
      end
      if (|bus.ack) begin
        exp_d = '0;
        for (int i = 0; i < N; i++)
          if (bus.ack[i]) exp_d = hist[2][i*W +: W];
        checks++;
        if (!pg || ppg) begin
          errors++;
          $display("FAIL soak_gtime%0d: got g hist %b%b want 01",
                   it, ppg, pg);
        end
        checks++;
        if (bus.lat_d !== exp_d || q !== exp_d) begin
          errors++;
          $display("FAIL soak_data%0d: got d=%h q=%h want %h",
                   it, bus.lat_d, q, exp_d);
        end
        expq = exp_d;
        pend = pend & ~bus.ack;
      end
      if (bus.clr_ack) begin
        checks++;
        if (!cpend) begin
          errors++;
          $display("FAIL soak_cack%0d: got clr_ack=1 want 0", it);
        end
        expq = '0;
        cpend = 1'b0;
      end
      if (!bus.busy) begin
        checks++;
        if (q !== expq) begin
          errors++;
          $display("FAIL soak_q%0d: got %h want %h", it, q, expq);
        end
      end
      ppg = pg;
      pg = bus.lat_g;
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          pend[i] = 1'b1;
      if (!cpend && $urandom_range(0, 15) == 0)
        cpend = 1'b1;
      wd = $urandom;
      bus.wdata = wd;
      bus.req = pend;
      bus.clr_req = cpend;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = wd;
    end
    bus.req = '0;
    bus.clr_req = 1'b0;
    n = 0;
    tick();
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL soak_drain: got busy=%b want 0 within 20 cycles",
               bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0;
    bus.wdata = '0;
    bus.clr_req = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_clear_priority();
    test_reset_mid_write();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
